// File: rtl/pulse_train_if.sv
// Handshake and line bundle between the game controller (master) and the
// pulse train generator (slave).
interface pulse_train_if #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
);
  logic             enable;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] act_len;
  logic [CNT_W-1:0] gap_len;
  logic [NUM_W-1:0] num_pulses;
  logic             line_out;
  logic             busy;
  logic             done;
  logic             edge_strobe;

  modport master (
    output enable, start, abort, act_len, gap_len, num_pulses,
    input  line_out, busy, done, edge_strobe
  );

  modport slave (
    input  enable, start, abort, act_len, gap_len, num_pulses,
    output line_out, busy, done, edge_strobe
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Drives one output line with a programmed train of active/gap pulses,
// timed in enable ticks, launched by start and cancelled by abort.
module pulse_train_gen #(
  parameter int   CNT_W      = 16,
  parameter int   NUM_W      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  pulse_train_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [NUM_W-1:0] rem_q, rem_d;
  logic             line_q, line_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             edge_q, edge_d;

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    gap_d   = gap_q;
    rem_d   = rem_q;
    line_d  = line_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    edge_d  = 1'b0;

    if (bus.abort) begin
      // Cancel drops the line to idle at once; no done for a cancelled train.
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
        rem_d   = '0;
        line_d  = IDLE_LEVEL;
        edge_d  = (line_q != IDLE_LEVEL);
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.num_pulses == '0 || bus.act_len == '0) begin
              done_d = 1'b1;
            end else begin
              act_d   = bus.act_len;
              gap_d   = (bus.gap_len == '0) ? CNT_W'(1) : bus.gap_len;
              rem_d   = bus.num_pulses - NUM_W'(1);
              cnt_d   = bus.act_len - CNT_W'(1);
              line_d  = ~IDLE_LEVEL;
              edge_d  = 1'b1;
              busy_d  = 1'b1;
              state_d = S_ACTIVE;
            end
          end
        end

        S_ACTIVE: begin
          if (bus.enable) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              line_d  = IDLE_LEVEL;
              edge_d  = 1'b1;
              cnt_d   = gap_q - CNT_W'(1);
              state_d = S_GAP;
            end
          end
        end

        S_GAP: begin
          if (bus.enable) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else if (rem_q != '0) begin
              rem_d   = rem_q - NUM_W'(1);
              cnt_d   = act_q - CNT_W'(1);
              line_d  = ~IDLE_LEVEL;
              edge_d  = 1'b1;
              state_d = S_ACTIVE;
            end else begin
              // Trailing gap finished: line is already idle.
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          line_d  = IDLE_LEVEL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
      gap_q   <= '0;
      rem_q   <= '0;
      line_q  <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      gap_q   <= gap_d;
      rem_q   <= rem_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      edge_q  <= edge_d;
    end
  end

  assign bus.line_out    = line_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.edge_strobe = edge_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: trains, sparse enable, rejects, abort,
// reset mid-train and start/abort corner cases.
module tb_pulse_train_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   n_busy;
  int   n_edge;
  int   n_done;
  logic exp_line;

  pulse_train_if #(.CNT_W(16), .NUM_W(8)) bus ();

  pulse_train_gen #(.CNT_W(16), .NUM_W(8), .IDLE_LEVEL(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_busy = 0;
    n_edge = 0;
    n_done = 0;
  endtask

  task automatic accumulate();
    n_busy += int'(bus.busy);
    n_edge += int'(bus.edge_strobe);
    n_done += int'(bus.done);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.enable     = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.act_len    = '0;
    bus.gap_len    = '0;
    bus.num_pulses = '0;

    // Reset values
    #12;
    check("rst_line", bus.line_out, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_edge", bus.edge_strobe, 0);
    rst_n = 1'b1;
    tick();

    // Train 1: act 3, gap 2, 2 pulses, enable tied high
    bus.act_len = 16'd3; bus.gap_len = 16'd2; bus.num_pulses = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    clear_counts();
    for (int i = 0; i < 11; i++) begin
      exp_line = (i < 10 && (i % 5) < 3) ? 1'b0 : 1'b1;
      check($sformatf("t1_line_%0d", i), bus.line_out, exp_line);
      accumulate();
      if (i == 10) check("t1_done_as_busy_falls", {bus.done, bus.busy}, 2'b10);
      tick();
    end
    check("t1_busy_cycles", n_busy, 10);
    check("t1_edges", n_edge, 4);
    check("t1_dones", n_done, 1);

    // Train 2: enable every 4th clk, act 2, gap 1, 1 pulse
    bus.enable = 1'b0;
    bus.act_len = 16'd2; bus.gap_len = 16'd1; bus.num_pulses = 8'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    clear_counts();
    accumulate();
    check("t2_line_0", bus.line_out, 0);
    for (int k = 1; k < 14; k++) begin
      bus.enable = ((k % 4) == 0);
      tick();
      exp_line = (k < 8) ? 1'b0 : 1'b1;
      check($sformatf("t2_line_%0d", k), bus.line_out, exp_line);
      check($sformatf("t2_done_%0d", k), bus.done, (k == 12) ? 1 : 0);
      accumulate();
    end
    check("t2_busy_cycles", n_busy, 12);
    check("t2_edges", n_edge, 2);
    bus.enable = 1'b1;

    // Rejects: num_pulses 0, then act_len 0
    bus.act_len = 16'd3; bus.gap_len = 16'd2; bus.num_pulses = 8'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rej_num_done", bus.done, 1);
    check("rej_num_busy", bus.busy, 0);
    check("rej_num_line", bus.line_out, 1);
    check("rej_num_edge", bus.edge_strobe, 0);
    tick();
    check("rej_num_done_one_cycle", bus.done, 0);
    bus.act_len = 16'd0; bus.num_pulses = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rej_act_done", bus.done, 1);
    check("rej_act_busy", bus.busy, 0);
    check("rej_act_line", bus.line_out, 1);
    check("rej_act_edge", bus.edge_strobe, 0);
    tick();
    check("rej_act_done_one_cycle", bus.done, 0);

    // Train 3: gap 0 treated as 1, act 1, 3 pulses
    bus.act_len = 16'd1; bus.gap_len = 16'd0; bus.num_pulses = 8'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    clear_counts();
    for (int i = 0; i < 7; i++) begin
      exp_line = (i < 6 && (i % 2) == 0) ? 1'b0 : 1'b1;
      check($sformatf("t3_line_%0d", i), bus.line_out, exp_line);
      accumulate();
      tick();
    end
    check("t3_busy_cycles", n_busy, 6);
    check("t3_edges", n_edge, 6);
    check("t3_dones", n_done, 1);

    // Abort in the 2nd active phase of a 5-pulse train
    bus.act_len = 16'd3; bus.gap_len = 16'd2; bus.num_pulses = 8'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ab_in_active2", {bus.busy, bus.line_out}, 2'b10);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("ab_line", bus.line_out, 1);
    check("ab_edge", bus.edge_strobe, 1);
    check("ab_busy", bus.busy, 0);
    check("ab_no_done", bus.done, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ab_restart_busy", bus.busy, 1);
    check("ab_restart_line", bus.line_out, 0);
    check("ab_restart_edge", bus.edge_strobe, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("ab2_busy", bus.busy, 0);
    tick();
    check("ab2_no_done", bus.done, 0);

    // Asynchronous reset during a gap
    bus.act_len = 16'd3; bus.gap_len = 16'd4; bus.num_pulses = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rg_in_gap", {bus.busy, bus.line_out}, 2'b11);
    rst_n = 1'b0;
    #2;
    check("rg_line", bus.line_out, 1);
    check("rg_busy", bus.busy, 0);
    check("rg_edge", bus.edge_strobe, 0);
    check("rg_done", bus.done, 0);
    rst_n = 1'b1;
    tick();
    check("rg_no_done_after", {bus.done, bus.busy}, 2'b00);

    // Start held high while busy, with changed inputs: train unaffected
    bus.act_len = 16'd2; bus.gap_len = 16'd1; bus.num_pulses = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("bs_line_0", bus.line_out, 0);
    for (int i = 1; i < 7; i++) begin
      bus.start = (i >= 2 && i <= 5);
      bus.act_len = (i >= 2) ? 16'd7 : 16'd2;
      bus.num_pulses = (i >= 2) ? 8'd9 : 8'd2;
      tick();
      exp_line = (i < 6 && (i % 3) != 2) ? 1'b0 : 1'b1;
      check($sformatf("bs_line_%0d", i), bus.line_out, exp_line);
      check($sformatf("bs_done_%0d", i), bus.done, (i == 6) ? 1 : 0);
    end
    bus.start = 1'b0;
    tick();
    check("bs_idle_after", bus.busy, 0);

    // Abort and start together in IDLE: nothing happens
    bus.act_len = 16'd3; bus.gap_len = 16'd2; bus.num_pulses = 8'd2;
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("as_busy", bus.busy, 0);
    check("as_line", bus.line_out, 1);
    check("as_edge", bus.edge_strobe, 0);
    check("as_done", bus.done, 0);

    // Maximum pulse count: 255 pulses of act 1, gap 1
    bus.act_len = 16'd1; bus.gap_len = 16'd1; bus.num_pulses = 8'd255;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    clear_counts();
    for (int i = 0; i < 512; i++) begin
      accumulate();
      tick();
    end
    check("max_busy_cycles", n_busy, 510);
    check("max_edges", n_edge, 510);
    check("max_dones", n_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
